multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode
// constants, ALUOp encodings, the default memory wait limit and the
// instruction legality check.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (accept BNE, Funct3=001).
package multicycle_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  localparam int WAIT_LIMIT_DEFAULT = 15;

  // True when the opcode/funct3 pair is an instruction this unit executes.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_LD, OP_SD: ok = 1'b1;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      OP_BR: ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
`else
      OP_BR: ok = (f3 == F3_BEQ);
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles. The counter is cleared whenever the
// FSM changes state; limit_hit flags the wait cycle that reaches LIMIT.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic cnt_en,
  output logic limit_hit
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  // Clear has priority; otherwise count each stalled cycle.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (cnt_en) begin
      count_next = count_reg + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // This stalled cycle is the LIMIT-th one in a row.
  assign limit_hit = cnt_en && (count_reg == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a
// sticky TRAP state for illegal instructions and memory wait timeouts.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (BNE taken when Zero=0).
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       Branch,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       IllegalInstr,
  output logic       BusError,
  output logic [2:0] State
);

  state_t     state_reg;
  state_t     state_next;
  logic [6:0] opcode_reg;
  logic [2:0] funct3_reg;
  logic       illegal_reg;
  logic       bus_error_reg;
  logic       decode_legal;
  logic       wait_en;
  logic       wait_clr;
  logic       wait_limit_hit;
  logic       branch_taken;
  alu_op_e    alu_op;

  assign decode_legal = is_legal(Opcode, Funct3);
  assign wait_en      = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !MemReady;
  assign wait_clr     = (state_next != state_reg);

  mem_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (wait_clr),
    .cnt_en   (wait_en),
    .limit_hit(wait_limit_hit)
  );

  // Branch resolution from the latched funct3 and the live zero flag.
  always_comb begin
    branch_taken = 1'b0;
    if (funct3_reg == F3_BEQ) begin
      branch_taken = Zero;
    end
`ifdef MULTICYCLE_CONTROL_BNE_EN
    else if (funct3_reg == F3_BNE) begin
      branch_taken = !Zero;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (MemReady)            state_next = ST_DECODE;
        else if (wait_limit_hit) state_next = ST_TRAP;
      end
      ST_DECODE: state_next = decode_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (opcode_reg)
          OP_R, OP_I:   state_next = ST_WB;
          OP_LD, OP_SD: state_next = ST_MEM;
          OP_BR:        state_next = ST_FETCH;
          default:      state_next = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (MemReady)            state_next = (opcode_reg == OP_LD) ? ST_WB : ST_FETCH;
        else if (wait_limit_hit) state_next = ST_TRAP;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_TRAP;
    endcase
  end

  // State register; the instruction fields are captured as DECODE is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_FETCH;
      opcode_reg <= '0;
      funct3_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) begin
        opcode_reg <= Opcode;
        funct3_reg <= Funct3;
      end
    end
  end

  // Sticky trap causes, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_DECODE) && !decode_legal) illegal_reg <= 1'b1;
      if (wait_limit_hit)                            bus_error_reg <= 1'b1;
    end
  end

  // Datapath controls decoded from the state and latched opcode. IRWrite and
  // PCWrite are masked while reset is held so no write strobes leak out.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    Branch   = 1'b0;
    ALUSrc   = 1'b0;
    alu_op   = ALU_ADD;
    case (state_reg)
      ST_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady && reset_n;
        PCWrite = MemReady && reset_n;
      end
      ST_EXEC: begin
        case (opcode_reg)
          OP_R: alu_op = ALU_FUNCT;
          OP_I: begin
            ALUSrc = 1'b1;
            alu_op = ALU_FUNCT;
          end
          OP_LD, OP_SD: ALUSrc = 1'b1;
          OP_BR: begin
            alu_op  = ALU_SUB;
            Branch  = 1'b1;
            PCWrite = branch_taken;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        MemRead  = (opcode_reg == OP_LD);
        MemWrite = (opcode_reg == OP_SD);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode_reg == OP_LD);
      end
      default: ;
    endcase
  end

  assign ALUOp        = alu_op;
  assign IllegalInstr = illegal_reg;
  assign BusError     = bus_error_reg;
  assign State        = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process builds the
// expected per-cycle behaviour of each instruction from the instruction rules
// and queues it; a monitor on the falling edge pops and compares.
module tb_multicycle_control;

  localparam int WL = 4;

  localparam logic [7:0] C_IRW = 8'h80;
  localparam logic [7:0] C_PCW = 8'h40;
  localparam logic [7:0] C_MR  = 8'h20;
  localparam logic [7:0] C_MW  = 8'h10;
  localparam logic [7:0] C_RW  = 8'h08;
  localparam logic [7:0] C_M2R = 8'h04;
  localparam logic [7:0] C_BR  = 8'h02;
  localparam logic [7:0] C_AS  = 8'h01;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] SD_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [7:0] ctl;
    logic [1:0] aop;
    logic       ill;
    logic       be;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic       IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Branch, ALUSrc;
  logic [1:0] ALUOp;
  logic       IllegalInstr, BusError;
  logic [2:0] State;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic exp_ill = 1'b0;
  logic exp_be  = 1'b0;
  int   abort_left = 0;

  multicycle_control #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
    .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .IllegalInstr(IllegalInstr), .BusError(BusError),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which instructions the control unit accepts.
  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == R_OP || op == I_OP || op == LD_OP || op == SD_OP) return 1'b1;
    if (op == BR_OP) begin
      if (f3 == 3'b000) return 1'b1;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      if (f3 == 3'b001) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
`ifdef MULTICYCLE_CONTROL_BNE_EN
    if (f3 == 3'b001) return !z;
`endif
    return (f3 == 3'b000) && z;
  endfunction

  function automatic exp_t mk(input string n, input logic [2:0] st, input logic [7:0] ctl,
                              input logic [1:0] aop);
    exp_t e;
    e.name = n; e.st = st; e.ctl = ctl; e.aop = aop; e.ill = exp_ill; e.be = exp_be;
    return e;
  endfunction

  // One clock of stimulus plus its expected outputs.
  task automatic cyc(input exp_t e, input logic rdy, input logic [6:0] opc,
                     input logic [2:0] f3, input logic z, input logic rst);
    @(posedge clk);
    #1;
    reset_n  = rst;
    MemReady = rdy;
    Opcode   = opc;
    Funct3   = f3;
    Zero     = z;
    sb.push_back(e);
  endtask

  // Inputs that must not matter in this cycle are randomised.
  task automatic cyc_r(input exp_t e, input logic rdy);
    cyc(e, rdy, 7'($urandom), 3'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    exp_ill = 1'b0;
    exp_be  = 1'b0;
    cyc(mk("reset", 3'd0, C_MR, 2'b00), 1'($urandom), 7'($urandom), 3'($urandom),
        1'($urandom), 1'b0);
  endtask

  task automatic trap_tail();
    repeat (2) cyc_r(mk("trap", 3'd5, 8'h00, 2'b00), 1'($urandom));
    do_reset();
  endtask

  // A post-fetch cycle, replaced by a reset pulse when the abort count hits.
  task automatic post(input exp_t e, input logic rdy, input logic [6:0] opc,
                      input logic [2:0] f3, input logic z, output bit aborted);
    aborted = 1'b0;
    if (abort_left == 1) begin
      abort_left = 0;
      do_reset();
      aborted = 1'b1;
    end else begin
      if (abort_left > 0) abort_left--;
      cyc(e, rdy, opc, f3, z, 1'b1);
    end
  endtask

  // Memory phase: mw stalled cycles, then completion or a timeout trap.
  task automatic mem_phase(input logic [7:0] ctl, input int mw, output bit stop);
    bit ab;
    stop = 1'b0;
    for (int k = 0; k < mw && k < WL; k++) begin
      post(mk("mem_wait", 3'd3, ctl, 2'b00), 1'b0, 7'($urandom), 3'($urandom),
           1'($urandom), ab);
      if (ab) begin stop = 1'b1; return; end
    end
    if (mw >= WL) begin
      exp_be = 1'b1;
      trap_tail();
      stop = 1'b1;
      return;
    end
    post(mk("mem_done", 3'd3, ctl, 2'b00), 1'b1, 7'($urandom), 3'($urandom),
         1'($urandom), ab);
    if (ab) stop = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, input int abort);
    bit ab;
    abort_left = abort;
    for (int k = 0; k < fw && k < WL; k++) cyc_r(mk("fetch_wait", 3'd0, C_MR, 2'b00), 1'b0);
    if (fw >= WL) begin
      exp_be = 1'b1;
      trap_tail();
      return;
    end
    cyc_r(mk("fetch", 3'd0, C_MR | C_IRW | C_PCW, 2'b00), 1'b1);
    post(mk("decode", 3'd1, 8'h00, 2'b00), 1'($urandom), opc, f3, 1'($urandom), ab);
    if (ab) return;
    if (!legal(opc, f3)) begin
      exp_ill = 1'b1;
      trap_tail();
      return;
    end
    case (opc)
      R_OP: begin
        post(mk("exec_r", 3'd2, 8'h00, 2'b10), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
        if (ab) return;
        post(mk("wb_r", 3'd4, C_RW, 2'b00), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
      end
      I_OP: begin
        post(mk("exec_i", 3'd2, C_AS, 2'b10), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
        if (ab) return;
        post(mk("wb_i", 3'd4, C_RW, 2'b00), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
      end
      LD_OP: begin
        post(mk("exec_ld", 3'd2, C_AS, 2'b00), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
        if (ab) return;
        mem_phase(C_MR, mw, ab);
        if (ab) return;
        post(mk("wb_ld", 3'd4, C_RW | C_M2R, 2'b00), 1'($urandom), 7'($urandom),
             3'($urandom), z, ab);
      end
      SD_OP: begin
        post(mk("exec_sd", 3'd2, C_AS, 2'b00), 1'($urandom), 7'($urandom), 3'($urandom), z, ab);
        if (ab) return;
        mem_phase(C_MW, mw, ab);
      end
      default: begin
        post(mk("exec_br", 3'd2, C_BR | (taken(f3, z) ? C_PCW : 8'h00), 2'b01),
             1'($urandom), 7'($urandom), 3'($urandom), z, ab);
      end
    endcase
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ({State, IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Branch, ALUSrc,
             ALUOp, IllegalInstr, BusError} != {e.st, e.ctl, e.aop, e.ill, e.be}) begin
          fails++;
          $display("FAIL %s: got st=%0d ctl=%b aluop=%b ill=%b be=%b, want st=%0d ctl=%b aluop=%b ill=%b be=%b",
                   e.name, State,
                   {IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Branch, ALUSrc},
                   ALUOp, IllegalInstr, BusError, e.st, e.ctl, e.aop, e.ill, e.be);
        end else begin
          $display("[TB] ok %s st=%0d ctl=%b aluop=%b", e.name, State,
                   {IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Branch, ALUSrc},
                   ALUOp);
        end
      end
    end
  end

  // Stimulus: directed corner cases, then random instruction streams.
  initial begin
    logic [6:0] ops[5];
    logic [6:0] opc;
    logic [2:0] f3;
    int         sel;
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = LD_OP; ops[3] = SD_OP; ops[4] = BR_OP;
    reset_n = 1'b1; MemReady = 1'b0; Opcode = '0; Funct3 = '0; Zero = 1'b0;

    do_reset();
    run_instr(R_OP, 3'b000, 1'b0, 0, 0, 0);
    run_instr(LD_OP, 3'b010, 1'b0, 0, 3, 0);
    run_instr(BR_OP, 3'b000, 1'b1, 0, 0, 0);
    run_instr(BR_OP, 3'b000, 1'b0, 0, 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0);
    run_instr(R_OP, 3'b000, 1'b0, 3, 0, 0);
    run_instr(R_OP, 3'b000, 1'b0, 4, 0, 0);
    run_instr(SD_OP, 3'b011, 1'b0, 0, 3, 0);
    run_instr(SD_OP, 3'b011, 1'b0, 0, 4, 0);
    run_instr(LD_OP, 3'b010, 1'b0, 0, 0, 4);
    run_instr(BR_OP, 3'b001, 1'b0, 0, 0, 0);
    run_instr(BR_OP, 3'b001, 1'b1, 0, 0, 0);
    run_instr(I_OP, 3'b000, 1'b0, 1, 0, 0);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 6);
      opc = (sel >= 5) ? 7'($urandom) : ops[sel];
      f3  = 3'($urandom);
      if (opc == BR_OP && $urandom_range(0, 2) != 0) f3 = 3'($urandom_range(0, 1));
      run_instr(opc, f3, 1'($urandom), $urandom_range(0, WL + 1), $urandom_range(0, WL + 1),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
